// File: rtl/ir_nec_pkg.sv
// Shared NEC IR framing definitions: FSM encoding and segment durations in NEC units.
// Intended for reuse by the matching NEC decoder.
package ir_nec_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LEAD_MARK  = 3'd1,
        LEAD_SPACE = 3'd2,
        BIT_MARK   = 3'd3,
        BIT_SPACE  = 3'd4,
        STOP_MARK  = 3'd5
    } nec_state_e;

    localparam logic [4:0] LEAD_MARK_UNITS  = 5'd16;
    localparam logic [4:0] LEAD_SPACE_UNITS = 5'd8;
    localparam logic [4:0] ONE_SPACE_UNITS  = 5'd3;
    localparam logic [4:0] ZERO_SPACE_UNITS = 5'd1;
    localparam logic [4:0] MARK_UNITS       = 5'd1;

    // Length of the current segment; the data space depends on the bit being sent.
    // IDLE returns 1 so callers can subtract one without wrapping.
    function automatic logic [4:0] segment_units(input nec_state_e st, input logic bit_val);
        logic [4:0] units;
        case (st)
            LEAD_MARK:  units = LEAD_MARK_UNITS;
            LEAD_SPACE: units = LEAD_SPACE_UNITS;
            BIT_SPACE:  units = bit_val ? ONE_SPACE_UNITS : ZERO_SPACE_UNITS;
            default:    units = MARK_UNITS;
        endcase
        return units;
    endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Carrier square wave for IR mark modulation. Restart forces phase high with a cleared
// counter so every mark begins on a high half-period.
module ir_carrier_gen
    import ir_nec_pkg::*;
#(
    parameter int CARRIER_HALF = 658
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic restart,
    output logic carrier
);

    localparam int CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CARRIER_HALF - 1);

    logic [CW-1:0] half_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            half_cnt <= '0;
            carrier  <= 1'b0;
        end else if (restart) begin
            half_cnt <= '0;
            carrier  <= 1'b1;
        end else if (enable) begin
            if (half_cnt == HALF_LAST) begin
                half_cnt <= '0;
                carrier  <= ~carrier;
            end else begin
                half_cnt <= half_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ir_nec_transmitter.sv
// NEC infrared transmitter: leader, N pulse-distance bits MSB first, stop mark,
// with marks gated by the carrier on ir_out.
module ir_nec_transmitter
    import ir_nec_pkg::*;
#(
    parameter int N            = 32,
    parameter int UNIT_CYCLES  = 28125,
    parameter int CARRIER_HALF = 658
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] data,
    input  logic         send,
    output logic         busy,
    output logic         done,
    output logic         envelope,
    output logic         ir_out,
    output nec_state_e   dbg_state
);

    localparam int UNIT_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam int BIT_W  = $clog2(N) + 1;
    localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(UNIT_CYCLES - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(N - 1);

    nec_state_e        state;
    logic [UNIT_W-1:0] unit_cnt;
    logic [4:0]        seg_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [N-1:0]      shift_reg;
    logic              seg_last_unit;
    logic              carrier;

    assign seg_last_unit = (seg_cnt == segment_units(state, shift_reg[N-1]) - 5'd1);
    assign dbg_state     = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            envelope  <= 1'b0;
            unit_cnt  <= '0;
            seg_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (send) begin
                    shift_reg <= data;
                    state     <= LEAD_MARK;
                    busy      <= 1'b1;
                    envelope  <= 1'b1;
                    unit_cnt  <= '0;
                    seg_cnt   <= '0;
                    bit_cnt   <= '0;
                end
            end else if (unit_cnt != UNIT_LAST) begin
                unit_cnt <= unit_cnt + 1'b1;
            end else begin
                unit_cnt <= '0;
                if (!seg_last_unit) begin
                    seg_cnt <= seg_cnt + 1'b1;
                end else begin
                    seg_cnt <= '0;
                    case (state)
                        LEAD_MARK: begin
                            state    <= LEAD_SPACE;
                            envelope <= 1'b0;
                        end
                        LEAD_SPACE: begin
                            state    <= BIT_MARK;
                            envelope <= 1'b1;
                        end
                        BIT_MARK: begin
                            state    <= BIT_SPACE;
                            envelope <= 1'b0;
                        end
                        // Next bit moves into the MSB only once its space has been timed.
                        BIT_SPACE: begin
                            shift_reg <= shift_reg << 1;
                            envelope  <= 1'b1;
                            if (bit_cnt == BIT_LAST) begin
                                state <= STOP_MARK;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                state   <= BIT_MARK;
                            end
                        end
                        STOP_MARK: begin
                            state    <= IDLE;
                            envelope <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end
                        default: begin
                            state    <= IDLE;
                            envelope <= 1'b0;
                            busy     <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    // Carrier is held in restart through every space, so each mark starts high.
    ir_carrier_gen #(
        .CARRIER_HALF(CARRIER_HALF)
    ) u_carrier (
        .clk    (clk),
        .reset  (reset),
        .enable (envelope),
        .restart(~envelope),
        .carrier(carrier)
    );

    assign ir_out = envelope & carrier;

endmodule

// File: tb/tb_ir_nec_transmitter.sv
// Bench for ir_nec_transmitter: envelope decoded by a receiver model, frames scoreboarded.
module tb_ir_nec_transmitter;
    import ir_nec_pkg::*;

    localparam int N            = 32;
    localparam int UNIT_CYCLES  = 4;
    localparam int CARRIER_HALF = 1;
    localparam int FRAME_BUDGET = 2000;

    logic         clk;
    logic         reset;
    logic [N-1:0] data;
    logic         send;
    logic         busy;
    logic         done;
    logic         envelope;
    logic         ir_out;
    nec_state_e   dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [N-1:0] exp_q[$];

    // Receiver-model state
    int         run;
    int         seg_idx;
    int         bits;
    int         len_err;
    int         carrier_err;
    int         space_ir_err;
    int         busy_cnt;
    int         done_cnt;
    int         lead_mark_len;
    int         lead_space_len;
    int         stop_len;
    logic [N-1:0] word;
    logic       prev_env;
    logic       in_frame;

    ir_nec_transmitter #(
        .N           (N),
        .UNIT_CYCLES (UNIT_CYCLES),
        .CARRIER_HALF(CARRIER_HALF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .data     (data),
        .send     (send),
        .busy     (busy),
        .done     (done),
        .envelope (envelope),
        .ir_out   (ir_out),
        .dbg_state(dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic int frame_cycles(input logic [N-1:0] d);
        int ones;
        ones = $countones(d);
        return UNIT_CYCLES * (25 + 2 * (N - ones) + 4 * ones);
    endfunction

    task automatic end_segment(input logic level, input int len);
        if (level) begin
            if (seg_idx == 0) lead_mark_len = len;
            else if (bits == N) stop_len = len;
            else if (len != UNIT_CYCLES) len_err++;
        end else begin
            if (seg_idx == 1) lead_space_len = len;
            else begin
                if (len == UNIT_CYCLES) word = {word[N-2:0], 1'b0};
                else if (len == 3 * UNIT_CYCLES) word = {word[N-2:0], 1'b1};
                else len_err++;
                bits++;
            end
        end
        seg_idx++;
    endtask

    task automatic finish_frame();
        logic [N-1:0] want;
        done_cnt++;
        check("busy_at_done", busy, 0);
        if (exp_q.size() == 0) begin
            check("unexpected_done", 1, 0);
        end else begin
            want = exp_q.pop_front();
            check("word", word, want);
            check("busy_cycles", busy_cnt, frame_cycles(want));
        end
        check("bit_count", bits, N);
        check("lead_mark", lead_mark_len, 16 * UNIT_CYCLES);
        check("lead_space", lead_space_len, 8 * UNIT_CYCLES);
        check("stop_mark", stop_len, UNIT_CYCLES);
        check("seg_len_err", len_err, 0);
        check("carrier_err", carrier_err, 0);
        check("space_ir_err", space_ir_err, 0);
        in_frame = 1'b0;
        busy_cnt = 0;
    endtask

    // Receiver model: measures envelope runs, checks ir_out against the envelope.
    always @(negedge clk) begin
        if (!reset) begin
            run = 0; prev_env = 1'b0; in_frame = 1'b0; busy_cnt = 0;
            seg_idx = 0; bits = 0; word = '0;
        end else begin
            if (envelope != prev_env) begin
                if (envelope && !in_frame) begin
                    in_frame = 1'b1; seg_idx = 0; bits = 0; word = '0; len_err = 0;
                    carrier_err = 0; space_ir_err = 0;
                    lead_mark_len = 0; lead_space_len = 0; stop_len = 0;
                end else if (in_frame) begin
                    end_segment(prev_env, run);
                end
                run = 0;
            end
            if (envelope) begin
                if (ir_out !== ((run % (2 * CARRIER_HALF)) < CARRIER_HALF)) carrier_err++;
            end else if (ir_out !== 1'b0) begin
                space_ir_err++;
            end
            run++;
            prev_env = envelope;
            if (busy) busy_cnt++;
            if (done) finish_frame();
        end
    end

    // Driver tasks
    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < FRAME_BUDGET) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt < target) check("done_timeout", done_cnt, target);
    endtask

    task automatic send_frame(input logic [N-1:0] d, input bit poke_busy);
        int target;
        target = done_cnt + 1;
        @(negedge clk);
        data = d;
        send = 1'b1;
        exp_q.push_back(d);
        @(negedge clk);
        send = 1'b0;
        check("accept_busy", busy, 1);
        check("accept_env", envelope, 1);
        check("accept_ir", ir_out, 1);
        if (poke_busy) begin
            repeat ($urandom_range(20, 200)) @(negedge clk);
            data = ~d;
            send = 1'b1;
            @(negedge clk);
            send = 1'b0;
        end
        wait_done(target);
    endtask

    initial begin
        logic [N-1:0] d;
        int target;
        reset = 1'b0;
        send  = 1'b0;
        data  = '0;
        len_err = 0; carrier_err = 0; space_ir_err = 0; done_cnt = 0;
        lead_mark_len = 0; lead_space_len = 0; stop_len = 0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_env", envelope, 0);
        check("rst_ir", ir_out, 0);
        reset = 1'b1;

        // Abandon a frame during a data space
        @(negedge clk);
        data = $urandom;
        send = 1'b1;
        exp_q.push_back(data);
        @(negedge clk);
        send = 1'b0;
        repeat (24 * UNIT_CYCLES + UNIT_CYCLES + 2) @(negedge clk);
        check("pre_rst_space", envelope, 0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_env", envelope, 0);
        check("midrst_ir", ir_out, 0);
        check("midrst_state", dbg_state, IDLE);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check("no_done_after_rst", done_cnt, 0);

        send_frame(32'h0000_0000, 1'b0);
        send_frame(32'hFFFF_FFFF, 1'b0);
        send_frame(32'h00FF_A25D, 1'b1);
        for (int i = 0; i < 2; i++) begin
            d = $urandom;
            send_frame(d, 1'b0);
        end

        // send held high: one frame, then a second starting right after done
        @(negedge clk);
        d = $urandom;
        data = d;
        send = 1'b1;
        exp_q.push_back(d);
        exp_q.push_back(d);
        target = done_cnt + 1;
        wait_done(target);
        @(negedge clk);
        check("held_refire_busy", busy, 1);
        check("held_refire_env", envelope, 1);
        send = 1'b0;
        wait_done(target + 1);

        repeat (10) @(negedge clk);
        check("done_total", done_cnt, 7);
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
